encoder_volume_ctrl: RTL and testbench

//  Front-panel volume controller between rotary-encoder decoder and audio/CPU side.

---
 rtl/encoder_volume_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_encoder_volume_ctrl.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_volume_ctrl.sv
// Front-panel volume controller: turns rotary-encoder strobes into a saturating
// volume target with speed acceleration and a mute toggle. The CPU may override
// the target. Every panel event is queued in a small FIFO for the CPU, and irq
// stays high while the FIFO holds anything.
// Optional build macro VOL_RAMP_EN: when defined, volume slews 1 LSB toward the
// target on each audio_clk_enable strobe instead of copying it every clock.
module encoder_volume_ctrl #(
    parameter logic [7:0]  VOL_MAX      = 8'd255,
    parameter logic [7:0]  VOL_DEFAULT  = 8'd128,
    parameter int unsigned ACCEL_WINDOW = 2000000,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       audio_clk_enable,
    input  logic       enc_state_change_stb,
    input  logic       click,
    input  logic       clockwise,
    input  logic       switch,
    input  logic       cpu_wr_stb,
    input  logic [7:0] cpu_wr_data,
    input  logic       cpu_rd_stb,
    output logic [7:0] volume,
    output logic [7:0] target,
    output logic       mute,
    output logic [7:0] event_data,
    output logic       irq
);

    localparam int unsigned      WIN_W    = $clog2(ACCEL_WINDOW + 1);
    localparam int unsigned      PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(ACCEL_WINDOW);

    // Panel-side state
    logic             swPrev_q, swPrev_d;
    logic [WIN_W-1:0] winCnt_q, winCnt_d;
    logic [1:0]       lvl_q, lvl_d;
    logic             lastDir_q, lastDir_d;
    logic [7:0]       target_q, target_d;
    logic [7:0]       volume_q, volume_d;
    logic             mute_q, mute_d;

    // Event FIFO state
    logic [6:0]       fifoMem_q [FIFO_DEPTH];
    logic [PTR_W:0]   wrPtr_q, wrPtr_d;
    logic [PTR_W:0]   rdPtr_q, rdPtr_d;
    logic             ovf_q, ovf_d;

    // Decoded events and intermediate values
    logic             clickEv;
    logic             pressEv;
    logic [1:0]       clickLvl;
    logic [1:0]       lvlStep;
    logic [7:0]       step;
    logic [8:0]       sum9;
    logic [7:0]       clickTarget;
    logic             fifoEmpty;
    logic             fifoFull;
    logic             pushReq;
    logic             pushOk;
    logic             popOk;
    logic [6:0]       entry;

    assign clickEv = enc_state_change_stb & click;
    assign pressEv = enc_state_change_stb & switch & ~swPrev_q;

    // Acceleration window, level update and saturating target arithmetic
    always_comb begin
        winCnt_d    = winCnt_q;
        clickLvl    = 2'd0;
        lvlStep     = lvl_q;
        lvl_d       = lvl_q;
        lastDir_d   = lastDir_q;
        swPrev_d    = swPrev_q;
        step        = 8'd1;
        sum9        = 9'd0;
        clickTarget = target_q;
        target_d    = target_q;
        mute_d      = mute_q ^ pressEv;

        if (enc_state_change_stb) begin
            swPrev_d = switch;
        end

        if (clickEv) begin
            winCnt_d = WIN_LOAD;
        end else if (winCnt_q != '0) begin
            winCnt_d = winCnt_q - WIN_W'(1);
        end

        if ((winCnt_q != '0) && (clockwise == lastDir_q)) begin
            clickLvl = (lvl_q >= 2'd2) ? 2'd2 : (lvl_q + 2'd1);
        end

        if (clickEv) begin
            lvlStep   = clickLvl;
            lastDir_d = clockwise;
        end else if (winCnt_d == '0) begin
            lvlStep = 2'd0;
        end

        step = 8'd1 << clickLvl;
        sum9 = {1'b0, target_q} + {1'b0, step};
        if (clockwise) begin
            clickTarget = (sum9 > {1'b0, VOL_MAX}) ? VOL_MAX : sum9[7:0];
        end else begin
            clickTarget = (target_q < step) ? 8'd0 : (target_q - step);
        end

        if (cpu_wr_stb) begin
            target_d = (cpu_wr_data > VOL_MAX) ? VOL_MAX : cpu_wr_data;
            lvl_d    = 2'd0;
        end else begin
            lvl_d = lvlStep;
            if (clickEv) begin
                target_d = clickTarget;
            end
        end
    end

    // Volume either copies the target or slews toward it on audio strobes
    always_comb begin
        volume_d = volume_q;
`ifdef VOL_RAMP_EN
        if (audio_clk_enable) begin
            if (volume_q < target_q) begin
                volume_d = volume_q + 8'd1;
            end else if (volume_q > target_q) begin
                volume_d = volume_q - 8'd1;
            end
        end
`else
        volume_d = target_q;
`endif
    end

`ifndef VOL_RAMP_EN
    logic unusedAudioEn;
    assign unusedAudioEn = audio_clk_enable;
`endif

    assign fifoEmpty = (wrPtr_q == rdPtr_q);
    assign fifoFull  = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) &&
                       (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);
    assign entry     = {ovf_q, mute_d, pressEv, clockwise, clickEv, lvlStep};

    // FIFO pointer and overflow bookkeeping; a pop frees room for a same-cycle push
    always_comb begin
        pushReq = clickEv | pressEv;
        popOk   = cpu_rd_stb & ~fifoEmpty;
        pushOk  = pushReq & (~fifoFull | popOk);
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        ovf_d   = ovf_q;

        if (pushOk) begin
            wrPtr_d = wrPtr_q + (PTR_W+1)'(1);
        end
        if (popOk) begin
            rdPtr_d = rdPtr_q + (PTR_W+1)'(1);
        end

        if (pushReq && !pushOk) begin
            ovf_d = 1'b1;
        end else if (popOk) begin
            ovf_d = 1'b0;
        end
    end

    // Register update for all resettable state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            swPrev_q  <= 1'b0;
            winCnt_q  <= '0;
            lvl_q     <= 2'd0;
            lastDir_q <= 1'b0;
            target_q  <= VOL_DEFAULT;
            volume_q  <= VOL_DEFAULT;
            mute_q    <= 1'b0;
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            swPrev_q  <= swPrev_d;
            winCnt_q  <= winCnt_d;
            lvl_q     <= lvl_d;
            lastDir_q <= lastDir_d;
            target_q  <= target_d;
            volume_q  <= volume_d;
            mute_q    <= mute_d;
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            ovf_q     <= ovf_d;
        end
    end

    // Event storage; contents are meaningless once the pointers are reset
    always_ff @(posedge clk) begin
        if (pushOk) begin
            fifoMem_q[wrPtr_q[PTR_W-1:0]] <= entry;
        end
    end

    assign volume     = volume_q;
    assign target     = target_q;
    assign mute       = mute_q;
    assign irq        = ~fifoEmpty;
    assign event_data = fifoEmpty ? 8'h00 : {1'b1, fifoMem_q[rdPtr_q[PTR_W-1:0]]};

endmodule

// File: tb/tb_encoder_volume_ctrl.sv
// Directed bench for encoder_volume_ctrl with a short acceleration window.
module tb_encoder_volume_ctrl;

    localparam int unsigned WIN = 40;

    logic       clk;
    logic       reset_n;
    logic       audio_clk_enable;
    logic       enc_state_change_stb;
    logic       click;
    logic       clockwise;
    logic       switch;
    logic       cpu_wr_stb;
    logic [7:0] cpu_wr_data;
    logic       cpu_rd_stb;
    logic [7:0] volume;
    logic [7:0] target;
    logic       mute;
    logic [7:0] event_data;
    logic       irq;

    int vecCount = 0;
    int errCount = 0;

    encoder_volume_ctrl #(
        .VOL_MAX      (8'd255),
        .VOL_DEFAULT  (8'd128),
        .ACCEL_WINDOW (WIN),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .audio_clk_enable     (audio_clk_enable),
        .enc_state_change_stb (enc_state_change_stb),
        .click                (click),
        .clockwise            (clockwise),
        .switch               (switch),
        .cpu_wr_stb           (cpu_wr_stb),
        .cpu_wr_data          (cpu_wr_data),
        .cpu_rd_stb           (cpu_rd_stb),
        .volume               (volume),
        .target               (target),
        .mute                 (mute),
        .event_data           (event_data),
        .irq                  (irq)
    );

    // Free-running clock, 10 time-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one cycle of inputs starting at a negedge; returns at the next negedge
    task automatic applyStimulus(input logic s, input logic c, input logic d,
                                 input logic sw, input logic rd, input logic wr,
                                 input logic [7:0] data);
        enc_state_change_stb = s;
        click                = c;
        clockwise            = d;
        switch               = sw;
        cpu_rd_stb           = rd;
        cpu_wr_stb           = wr;
        cpu_wr_data          = data;
        @(negedge clk);
        enc_state_change_stb = 1'b0;
        click                = 1'b0;
        cpu_rd_stb           = 1'b0;
        cpu_wr_stb           = 1'b0;
        cpu_wr_data          = 8'h00;
    endtask

    task automatic clickCw();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic clickCcw();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic popEvent();
        applyStimulus(1'b0, 1'b0, 1'b0, switch, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic cpuWrite(input logic [7:0] data);
        applyStimulus(1'b0, 1'b0, 1'b0, switch, 1'b0, 1'b1, data);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic resetDut();
        @(negedge clk);
        reset_n              = 1'b0;
        audio_clk_enable     = 1'b0;
        enc_state_change_stb = 1'b0;
        click                = 1'b0;
        clockwise            = 1'b0;
        switch               = 1'b0;
        cpu_wr_stb           = 1'b0;
        cpu_wr_data          = 8'h00;
        cpu_rd_stb           = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetDut();
        vecCount++;
        if ({target, volume, mute, irq, event_data} !== {8'd128, 8'd128, 1'b0, 1'b0, 8'h00}) begin
            errCount++;
            $display("[TB] FAIL reset_state: got t=%0d v=%0d m=%0b irq=%0b ev=%h, expected t=128 v=128 m=0 irq=0 ev=00",
                     target, volume, mute, irq, event_data);
        end
    endtask

    task automatic test_accel();
        logic [7:0] expT [3];
        logic [7:0] expE [3];
        expT[0] = 8'd129; expT[1] = 8'd131; expT[2] = 8'd135;
        expE[0] = 8'h8C;  expE[1] = 8'h8D;  expE[2] = 8'h8E;
        resetDut();
        for (int i = 0; i < 3; i++) begin
            clickCw();
            vecCount++;
            if (target !== expT[i]) begin
                errCount++;
                $display("[TB] FAIL accel_target%0d: got %0d expected %0d", i, target, expT[i]);
            end
`ifndef VOL_RAMP_EN
            if (i == 0) begin
                vecCount++;
                if (volume !== 8'd128) begin
                    errCount++;
                    $display("[TB] FAIL accel_volume_lag: got %0d expected 128", volume);
                end
            end
`endif
            if (i < 2) idle(9);
        end
        idle(1);
`ifndef VOL_RAMP_EN
        vecCount++;
        if (volume !== 8'd135) begin
            errCount++;
            $display("[TB] FAIL accel_volume: got %0d expected 135", volume);
        end
`endif
        for (int i = 0; i < 3; i++) begin
            vecCount++;
            if ({irq, event_data} !== {1'b1, expE[i]}) begin
                errCount++;
                $display("[TB] FAIL accel_event%0d: got irq=%0b ev=%h expected irq=1 ev=%h", i, irq, event_data, expE[i]);
            end
            popEvent();
        end
        vecCount++;
        if ({irq, event_data} !== {1'b0, 8'h00}) begin
            errCount++;
            $display("[TB] FAIL accel_drained: got irq=%0b ev=%h expected irq=0 ev=00", irq, event_data);
        end
    endtask

    task automatic test_saturation();
        logic [7:0] expUp [4];
        logic [7:0] expDn [4];
        expUp[0] = 8'd248; expUp[1] = 8'd250; expUp[2] = 8'd254; expUp[3] = 8'd255;
        expDn[0] = 8'd7;   expDn[1] = 8'd5;   expDn[2] = 8'd1;   expDn[3] = 8'd0;
        resetDut();
        cpuWrite(8'd247);
        for (int i = 0; i < 4; i++) begin
            idle(4);
            clickCw();
            vecCount++;
            if (target !== expUp[i]) begin
                errCount++;
                $display("[TB] FAIL sat_up%0d: got %0d expected %0d", i, target, expUp[i]);
            end
        end
        cpuWrite(8'd8);
        vecCount++;
        if (target !== 8'd8) begin
            errCount++;
            $display("[TB] FAIL sat_cpu_load: got %0d expected 8", target);
        end
        for (int i = 0; i < 4; i++) begin
            idle(4);
            clickCcw();
            vecCount++;
            if (target !== expDn[i]) begin
                errCount++;
                $display("[TB] FAIL sat_down%0d: got %0d expected %0d", i, target, expDn[i]);
            end
        end
    endtask

    task automatic test_window();
        logic [7:0] expT [5];
        expT[0] = 8'd129; expT[1] = 8'd131; expT[2] = 8'd132; expT[3] = 8'd134; expT[4] = 8'd133;
        resetDut();
        clickCw();
        idle(WIN - 1);
        clickCw();
        idle(WIN);
        clickCw();
        clickCw();
        clickCcw();
        vecCount++;
        if (target !== expT[4]) begin
            errCount++;
            $display("[TB] FAIL window_sequence: got %0d expected %0d", target, expT[4]);
        end
        resetDut();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: clickCw();
                1: begin idle(WIN - 1); clickCw(); end
                2: begin idle(WIN); clickCw(); end
                3: clickCw();
                default: clickCcw();
            endcase
            vecCount++;
            if (target !== expT[i]) begin
                errCount++;
                $display("[TB] FAIL window_step%0d: got %0d expected %0d", i, target, expT[i]);
            end
        end
    endtask

    task automatic test_mute();
        logic       swSeq [4];
        logic       expM  [4];
        logic [7:0] expE  [4];
        swSeq[0] = 1'b1; swSeq[1] = 1'b1; swSeq[2] = 1'b0; swSeq[3] = 1'b1;
        expM[0]  = 1'b1; expM[1]  = 1'b1; expM[2]  = 1'b1; expM[3]  = 1'b0;
        expE[0] = 8'hB0; expE[1] = 8'h90; expE[2] = 8'hBC; expE[3] = 8'hAD;
        resetDut();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, swSeq[i], 1'b0, 1'b0, 8'h00);
            vecCount++;
            if (mute !== expM[i]) begin
                errCount++;
                $display("[TB] FAIL mute_toggle%0d: got %0b expected %0b", i, mute, expM[i]);
            end
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        clickCw();
        vecCount++;
        if ({mute, target} !== {1'b1, 8'd131}) begin
            errCount++;
            $display("[TB] FAIL mute_click_combo: got m=%0b t=%0d expected m=1 t=131", mute, target);
        end
        for (int i = 0; i < 4; i++) begin
            vecCount++;
            if (event_data !== expE[i]) begin
                errCount++;
                $display("[TB] FAIL mute_event%0d: got %h expected %h", i, event_data, expE[i]);
            end
            popEvent();
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] expE [4];
        expE[0] = 8'h84; expE[1] = 8'h8C; expE[2] = 8'h84; expE[3] = 8'hC4;
        resetDut();
        clickCw();
        clickCcw();
        clickCw();
        clickCcw();
        vecCount++;
        if ({irq, event_data} !== {1'b1, 8'h8C}) begin
            errCount++;
            $display("[TB] FAIL fifo_full_head: got irq=%0b ev=%h expected irq=1 ev=8c", irq, event_data);
        end
        clickCw();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            vecCount++;
            if (event_data !== expE[i]) begin
                errCount++;
                $display("[TB] FAIL fifo_entry%0d: got %h expected %h", i, event_data, expE[i]);
            end
            popEvent();
        end
        vecCount++;
        if ({irq, event_data} !== {1'b0, 8'h00}) begin
            errCount++;
            $display("[TB] FAIL fifo_empty: got irq=%0b ev=%h expected irq=0 ev=00", irq, event_data);
        end
        popEvent();
        clickCw();
        vecCount++;
        if ({irq, event_data} !== {1'b1, 8'h8C}) begin
            errCount++;
            $display("[TB] FAIL fifo_ovf_cleared: got irq=%0b ev=%h expected irq=1 ev=8c", irq, event_data);
        end
    endtask

    task automatic test_cpu_write();
        resetDut();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hC8);
        vecCount++;
        if ({target, irq, event_data} !== {8'd200, 1'b1, 8'h8C}) begin
            errCount++;
            $display("[TB] FAIL cpu_wins: got t=%0d irq=%0b ev=%h expected t=200 irq=1 ev=8c", target, irq, event_data);
        end
        idle(1);
`ifdef VOL_RAMP_EN
        vecCount++;
        if (volume !== 8'd128) begin
            errCount++;
            $display("[TB] FAIL ramp_hold: got %0d expected 128", volume);
        end
        audio_clk_enable = 1'b1;
        idle(71);
        audio_clk_enable = 1'b0;
        vecCount++;
        if (volume !== 8'd199) begin
            errCount++;
            $display("[TB] FAIL ramp_71: got %0d expected 199", volume);
        end
        audio_clk_enable = 1'b1;
        idle(3);
        audio_clk_enable = 1'b0;
        vecCount++;
        if (volume !== 8'd200) begin
            errCount++;
            $display("[TB] FAIL ramp_final: got %0d expected 200", volume);
        end
`else
        vecCount++;
        if (volume !== 8'd200) begin
            errCount++;
            $display("[TB] FAIL cpu_volume: got %0d expected 200", volume);
        end
`endif
    endtask

    task automatic test_reset_midop();
        resetDut();
        clickCw();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        #2;
        reset_n = 1'b0;
        #1;
        vecCount++;
        if ({target, volume, mute, irq, event_data} !== {8'd128, 8'd128, 1'b0, 1'b0, 8'h00}) begin
            errCount++;
            $display("[TB] FAIL midop_reset: got t=%0d v=%0d m=%0b irq=%0b ev=%h, expected t=128 v=128 m=0 irq=0 ev=00",
                     target, volume, mute, irq, event_data);
        end
        switch = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        clickCw();
        vecCount++;
        if ({target, event_data} !== {8'd129, 8'h8C}) begin
            errCount++;
            $display("[TB] FAIL midop_after: got t=%0d ev=%h expected t=129 ev=8c", target, event_data);
        end
    endtask

    // Runs each scenario in turn and prints the summary
    initial begin
        reset_n              = 1'b0;
        audio_clk_enable     = 1'b0;
        enc_state_change_stb = 1'b0;
        click                = 1'b0;
        clockwise            = 1'b0;
        switch               = 1'b0;
        cpu_wr_stb           = 1'b0;
        cpu_wr_data          = 8'h00;
        cpu_rd_stb           = 1'b0;
        test_reset();
        test_accel();
        test_saturation();
        test_window();
        test_mute();
        test_back_to_back();
        test_cpu_write();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
